// File: rtl/pc_branch_sequencer_pkg.sv
// Shared CPU front-end definitions: sequencer states, PC step and branch offset width.
package pc_branch_sequencer_pkg;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_PEND  = 2'd1;
  localparam logic [1:0] ST_REDIR = 2'd2;

  localparam int unsigned PcIncrement = 32'd4;
  localparam int unsigned OffsetBits  = 32'd16;

endpackage

// File: rtl/pc_return_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
// Instantiated by pc_branch_sequencer only when PC_BRANCH_SEQUENCER_RETURN_STACK_EN is defined.
module pc_return_stack
  import pc_branch_sequencer_pkg::*;
#(
  parameter int NrOfBits = 32,
  parameter int RasDepth = 4
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                push_i,
  input  logic                pop_i,
  input  logic [NrOfBits-1:0] push_addr_i,
  output logic [NrOfBits-1:0] top_o,
  output logic                empty_o
);

  localparam int PtrBits = $clog2(RasDepth);
  localparam int CntBits = $clog2(RasDepth + 1);

  logic [NrOfBits-1:0] mem_q [RasDepth];
  logic [PtrBits-1:0]  wptr_q, wptr_d;
  logic [CntBits-1:0]  cnt_q, cnt_d;
  logic                full_s;

  assign full_s  = (cnt_q == CntBits'(RasDepth));
  assign empty_o = (cnt_q == {CntBits{1'b0}});
  assign top_o   = mem_q[wptr_q - PtrBits'(1)];

  // Pointer and occupancy update; the count saturates so overwriting keeps the stack full.
  always_comb begin
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    if (push_i) begin
      wptr_d = wptr_q + PtrBits'(1);
      cnt_d  = full_s ? cnt_q : cnt_q + CntBits'(1);
    end else if (pop_i && !empty_o) begin
      wptr_d = wptr_q - PtrBits'(1);
      cnt_d  = cnt_q - CntBits'(1);
    end else begin
      wptr_d = wptr_q;
      cnt_d  = cnt_q;
    end
  end

  // Stack storage and pointers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wptr_q <= {PtrBits{1'b0}};
      cnt_q  <= {CntBits{1'b0}};
      for (int i = 0; i < RasDepth; i++) begin
        mem_q[i] <= {NrOfBits{1'b0}};
      end
    end else begin
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
      if (push_i) begin
        mem_q[wptr_q] <= push_addr_i;
      end
    end
  end

endmodule

// File: rtl/pc_branch_sequencer.sv
// Fetch PC sequencer with branch/jump/call/return redirect, stall handling and flush strobe.
// Define PC_BRANCH_SEQUENCER_RETURN_STACK_EN to compile in the return-address stack.
module pc_branch_sequencer
  import pc_branch_sequencer_pkg::*;
#(
  parameter int                  NrOfBits    = 32,
  parameter logic [NrOfBits-1:0] ResetVector = '0,
  parameter int                  RasDepth    = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Tick,
  input  logic                  Stall,
  input  logic                  BranchValid,
  input  logic                  BranchTaken,
  input  logic [NrOfBits-1:0]   BranchBase,
  input  logic [OffsetBits-1:0] BranchOffset,
  input  logic                  JumpValid,
  input  logic [NrOfBits-1:0]   JumpTarget,
  input  logic                  CallValid,
  input  logic                  RetValid,
  output logic [NrOfBits-1:0]   PC,
  output logic [NrOfBits-1:0]   BranchInstructionAddress,
  output logic                  BaLoad,
  output logic                  Flush,
  output logic                  RasEmpty
);

  logic [1:0]          state_q, state_d;
  logic [NrOfBits-1:0] pc_q, pc_d;
  logic [NrOfBits-1:0] bia_q, bia_d;
  logic [NrOfBits-1:0] pend_q, pend_d;
  logic                baload_q, baload_d;
  logic                flush_q, flush_d;

  logic [NrOfBits-1:0] pc_inc_s;
  logic [NrOfBits-1:0] offset_ext_s;
  logic [NrOfBits-1:0] branch_tgt_s;
  logic [NrOfBits-1:0] tgt_s;
  logic                req_s;
  logic                call_sel_s;
  logic                ret_sel_s;
  logic                ret_en_s;
  logic                accept_s;
  logic                ras_push_s;
  logic                ras_pop_s;
  logic [NrOfBits-1:0] ras_top_s;
  logic                ras_empty_s;

  assign pc_inc_s     = pc_q + NrOfBits'(PcIncrement);
  assign offset_ext_s = {{(NrOfBits-OffsetBits){BranchOffset[OffsetBits-1]}}, BranchOffset};
  assign branch_tgt_s = BranchBase + {offset_ext_s[NrOfBits-3:0], 2'b00};

  // Stack side effects happen only when a request is actually taken from RUN.
  assign accept_s   = Tick && (state_q == ST_RUN);
  assign ras_push_s = accept_s && call_sel_s;
  assign ras_pop_s  = accept_s && ret_sel_s;

`ifdef PC_BRANCH_SEQUENCER_RETURN_STACK_EN
  assign ret_en_s = RetValid;

  pc_return_stack #(
    .NrOfBits (NrOfBits),
    .RasDepth (RasDepth)
  ) u_ras (
    .Clock       (Clock),
    .Reset       (Reset),
    .push_i      (ras_push_s),
    .pop_i       (ras_pop_s),
    .push_addr_i (pc_inc_s),
    .top_o       (ras_top_s),
    .empty_o     (ras_empty_s)
  );
`else
  logic unused_ras_s;

  assign ret_en_s     = 1'b0;
  assign ras_top_s    = ResetVector;
  assign ras_empty_s  = 1'b1;
  assign unused_ras_s = RetValid ^ ras_push_s ^ ras_pop_s;
`endif

  assign RasEmpty = ras_empty_s;

  // Request arbitration: return > call > jump > taken branch.
  always_comb begin
    req_s      = 1'b0;
    call_sel_s = 1'b0;
    ret_sel_s  = 1'b0;
    tgt_s      = {NrOfBits{1'b0}};
    if (ret_en_s) begin
      req_s     = 1'b1;
      ret_sel_s = 1'b1;
      tgt_s     = ras_empty_s ? ResetVector : ras_top_s;
    end else if (CallValid) begin
      req_s      = 1'b1;
      call_sel_s = 1'b1;
      tgt_s      = JumpTarget;
    end else if (JumpValid) begin
      req_s = 1'b1;
      tgt_s = JumpTarget;
    end else if (BranchValid && BranchTaken) begin
      req_s = 1'b1;
      tgt_s = branch_tgt_s;
    end else begin
      req_s = 1'b0;
    end
  end

  // Sequencer next state; nothing moves on a cycle without Tick.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    bia_d    = bia_q;
    pend_d   = pend_q;
    baload_d = baload_q;
    flush_d  = flush_q;
    if (Tick) begin
      case (state_q)
        ST_RUN: begin
          flush_d = 1'b0;
          if (req_s && Stall) begin
            pend_d   = tgt_s;
            baload_d = 1'b0;
            state_d  = ST_PEND;
          end else if (req_s) begin
            pc_d     = tgt_s;
            bia_d    = tgt_s;
            baload_d = 1'b1;
            state_d  = ST_REDIR;
          end else begin
            baload_d = 1'b0;
            pc_d     = Stall ? pc_q : pc_inc_s;
          end
        end
        ST_PEND: begin
          flush_d = 1'b0;
          if (Stall) begin
            baload_d = 1'b0;
          end else begin
            pc_d     = pend_q;
            bia_d    = pend_q;
            pend_d   = {NrOfBits{1'b0}};
            baload_d = 1'b1;
            state_d  = ST_REDIR;
          end
        end
        ST_REDIR: begin
          baload_d = 1'b0;
          flush_d  = 1'b1;
          pc_d     = Stall ? pc_q : pc_inc_s;
          state_d  = ST_RUN;
        end
        default: begin
          baload_d = 1'b0;
          flush_d  = 1'b0;
          state_d  = ST_RUN;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_RUN;
      pc_q     <= ResetVector;
      bia_q    <= {NrOfBits{1'b0}};
      pend_q   <= {NrOfBits{1'b0}};
      baload_q <= 1'b0;
      flush_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      bia_q    <= bia_d;
      pend_q   <= pend_d;
      baload_q <= baload_d;
      flush_q  <= flush_d;
    end
  end

  assign PC                       = pc_q;
  assign BranchInstructionAddress = bia_q;
  assign BaLoad                   = baload_q;
  assign Flush                    = flush_q;

endmodule

// File: tb/tb_pc_branch_sequencer.sv
// Scoreboard bench for pc_branch_sequencer: directed scenarios plus randomized traffic
// against a behavioural model of the fetch sequencer.
module tb_pc_branch_sequencer;

  localparam int          W     = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RV    = 32'h0000_0000;
`ifdef PC_BRANCH_SEQUENCER_RETURN_STACK_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  logic          Clock = 1'b0;
  logic          Reset, Tick, Stall, BranchValid, BranchTaken, JumpValid, CallValid, RetValid;
  logic [W-1:0]  BranchBase, JumpTarget, PC, BranchInstructionAddress;
  logic [15:0]   BranchOffset;
  logic          BaLoad, Flush, RasEmpty;

  pc_branch_sequencer #(.NrOfBits(W), .ResetVector(RV), .RasDepth(DEPTH)) dut (
    .Clock(Clock), .Reset(Reset), .Tick(Tick), .Stall(Stall),
    .BranchValid(BranchValid), .BranchTaken(BranchTaken),
    .BranchBase(BranchBase), .BranchOffset(BranchOffset),
    .JumpValid(JumpValid), .JumpTarget(JumpTarget),
    .CallValid(CallValid), .RetValid(RetValid),
    .PC(PC), .BranchInstructionAddress(BranchInstructionAddress),
    .BaLoad(BaLoad), .Flush(Flush), .RasEmpty(RasEmpty)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] bia;
    logic        baload;
    logic        flush;
    logic        ras_empty;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Reference model: architectural view of the fetch stream.
  logic [31:0] m_pc, m_bia, m_waiting_tgt;
  bit          m_baload, m_flush, m_waiting, m_flush_next;
  logic [31:0] m_stack[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RV; m_bia = 32'h0; m_waiting_tgt = 32'h0;
    m_baload = 1'b0; m_flush = 1'b0; m_waiting = 1'b0; m_flush_next = 1'b0;
    m_stack.delete();
  endtask

  task automatic model_redirect(logic [31:0] tgt);
    m_pc = tgt; m_bia = tgt; m_baload = 1'b1; m_flush_next = 1'b1;
  endtask

  // Predict the outputs after the coming rising edge from the inputs now applied.
  task automatic model_step();
    logic [31:0] tgt;
    bit          req;
    int          off;
    tgt = 32'h0;
    if (Tick) begin
      if (m_flush_next) begin
        m_flush = 1'b1; m_baload = 1'b0; m_flush_next = 1'b0;
        if (!Stall) m_pc = m_pc + 32'd4;
      end else if (m_waiting) begin
        m_flush = 1'b0;
        if (Stall) m_baload = 1'b0;
        else begin model_redirect(m_waiting_tgt); m_waiting = 1'b0; end
      end else begin
        m_flush = 1'b0;
        req = 1'b1;
        if (RAS_EN && RetValid) begin
          tgt = (m_stack.size() == 0) ? RV : m_stack.pop_back();
        end else if (CallValid) begin
          tgt = JumpTarget;
          if (RAS_EN) begin
            m_stack.push_back(m_pc + 32'd4);
            if (m_stack.size() > DEPTH) m_stack.delete(0);
          end
        end else if (JumpValid) begin
          tgt = JumpTarget;
        end else if (BranchValid && BranchTaken) begin
          off = $signed(BranchOffset);
          tgt = BranchBase + off * 4;
        end else begin
          req = 1'b0;
        end
        if (!req) begin
          m_baload = 1'b0;
          if (!Stall) m_pc = m_pc + 32'd4;
        end else if (Stall) begin
          m_waiting_tgt = tgt; m_waiting = 1'b1; m_baload = 1'b0;
        end else begin
          model_redirect(tgt);
        end
      end
    end
    exp_q.push_back('{m_pc, m_bia, m_baload, m_flush, (RAS_EN ? (m_stack.size() == 0) : 1'b1)});
  endtask

  // Monitor: compares each cycle's outputs shortly after the rising edge.
  always @(posedge Clock) begin
    #2;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("pc", PC, mon_e.pc);
      check("bia", BranchInstructionAddress, mon_e.bia);
      check("baload", {31'd0, BaLoad}, {31'd0, mon_e.baload});
      check("flush", {31'd0, Flush}, {31'd0, mon_e.flush});
      check("ras_empty", {31'd0, RasEmpty}, {31'd0, mon_e.ras_empty});
    end
  end

  task automatic idle();
    Tick = 1'b1; Stall = 1'b0; BranchValid = 1'b0; BranchTaken = 1'b0;
    JumpValid = 1'b0; CallValid = 1'b0; RetValid = 1'b0;
    BranchBase = 32'h0; BranchOffset = 16'h0; JumpTarget = 32'h0;
  endtask

  task automatic step();
    model_step();
    @(negedge Clock);
  endtask

  // Asynchronous reset, checked immediately, released on the next falling edge.
  task automatic do_reset();
    Reset = 1'b1;
    #1;
    check("rst_pc", PC, RV);
    check("rst_bia", BranchInstructionAddress, 32'h0);
    check("rst_baload", {31'd0, BaLoad}, 32'd0);
    check("rst_flush", {31'd0, Flush}, 32'd0);
    check("rst_ras_empty", {31'd0, RasEmpty}, 32'd1);
    model_reset();
    exp_q.delete();
    idle();
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] held;
    logic [31:0] ret_exp [5];
    idle();
    Reset = 1'b1;
    @(negedge Clock);
    do_reset();

    // Free-running fetch after reset.
    for (int i = 1; i <= 3; i++) begin
      step();
      check("run_pc", PC, 32'd4 * i);
      check("run_baload", {31'd0, BaLoad}, 32'd0);
    end

    // Reach 0x100 via a jump to 0xFC, then branch back by two words.
    JumpValid = 1'b1; JumpTarget = 32'hFC; step(); idle();
    step();
    check("pre_branch_pc", PC, 32'h100);
    BranchValid = 1'b1; BranchTaken = 1'b1; BranchBase = 32'h100; BranchOffset = 16'hFFFE;
    step(); idle();
    check("br_pc", PC, 32'hF8);
    check("br_bia", BranchInstructionAddress, 32'hF8);
    check("br_baload", {31'd0, BaLoad}, 32'd1);
    step();
    check("br_flush", {31'd0, Flush}, 32'd1);
    check("br_baload_off", {31'd0, BaLoad}, 32'd0);
    check("br_pc_next", PC, 32'hFC);
    step();
    check("br_flush_off", {31'd0, Flush}, 32'd0);

    // Not-taken branch is a no-op.
    held = PC;
    BranchValid = 1'b1; BranchTaken = 1'b0; BranchBase = 32'h0; BranchOffset = 16'h7; step(); idle();
    check("nt_pc", PC, held + 32'd4);

    // Jump under stall waits, then fires on release.
    held = PC;
    Stall = 1'b1; JumpValid = 1'b1; JumpTarget = 32'h40; step();
    JumpValid = 1'b0; step(); step();
    check("stall_pc_held", PC, held);
    check("stall_no_baload", {31'd0, BaLoad}, 32'd0);
    Stall = 1'b0; step();
    check("release_pc", PC, 32'h40);
    check("release_baload", {31'd0, BaLoad}, 32'd1);
    step();

    // Jump beats a taken branch; a request during the redirect cycle is dropped.
    JumpValid = 1'b1; JumpTarget = 32'h200;
    BranchValid = 1'b1; BranchTaken = 1'b1; BranchBase = 32'h0; BranchOffset = 16'h5;
    step(); idle();
    check("prio_pc", PC, 32'h200);
    JumpValid = 1'b1; JumpTarget = 32'h300; step(); idle();
    check("redir_ignore_pc", PC, 32'h204);
    step();
    check("redir_ignore_baload", {31'd0, BaLoad}, 32'd0);
    check("redir_ignore_pc2", PC, 32'h208);

    // No Tick: everything holds even with a request present.
    held = PC;
    Tick = 1'b0; JumpValid = 1'b1; JumpTarget = 32'h500; step(); step(); idle();
    check("notick_pc", PC, held);

    // Reset while a redirect is pending drops it.
    Stall = 1'b1; JumpValid = 1'b1; JumpTarget = 32'h80; step(); idle();
    do_reset();
    step();
    check("pend_rst_pc", PC, RV + 32'd4);
    check("pend_rst_baload", {31'd0, BaLoad}, 32'd0);
    step();

`ifdef PC_BRANCH_SEQUENCER_RETURN_STACK_EN
    do_reset();
    JumpValid = 1'b1; JumpTarget = 32'h0C; step(); idle(); step();
    for (int k = 1; k <= 5; k++) begin
      check("call_from_pc", PC, 32'h10 * k);
      CallValid = 1'b1; JumpTarget = 32'h10 * k + 32'h0C; step(); idle(); step();
    end
    ret_exp[0] = 32'h54; ret_exp[1] = 32'h44; ret_exp[2] = 32'h34; ret_exp[3] = 32'h24; ret_exp[4] = RV;
    for (int k = 0; k < 5; k++) begin
      RetValid = 1'b1; step(); idle();
      check("ret_target", BranchInstructionAddress, ret_exp[k]);
      step();
    end
    check("ret_empty", {31'd0, RasEmpty}, 32'd1);
`endif

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      idle();
      if ($urandom_range(0, 249) == 0) begin
        do_reset();
      end else begin
        Tick         = ($urandom_range(0, 9) != 0);
        Stall        = ($urandom_range(0, 3) == 0);
        BranchValid  = ($urandom_range(0, 99) < 15);
        BranchTaken  = $urandom_range(0, 1) == 1;
        BranchBase   = $urandom;
        BranchOffset = 16'($urandom);
        JumpValid    = ($urandom_range(0, 99) < 6);
        JumpTarget   = $urandom & 32'hFFFF_FFFC;
        CallValid    = ($urandom_range(0, 99) < 5);
        RetValid     = ($urandom_range(0, 99) < 5);
        step();
      end
    end
    idle();
    step();

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_branch_sequencer.md
PC_BRANCH_SEQUENCER -- requirements
Module: pc_branch_sequencer

Interface
REQ-001 SHALL have parameter NrOfBits, default 32, meaning address width in bits.
REQ-002 SHALL have parameter ResetVector, default 0, meaning the PC value after reset.
REQ-003 SHALL have parameter RasDepth, default 4, meaning return-stack entries (power of two).
REQ-004 SHALL have port Clock, input, 1 bit, the system clock; all state changes on its rising edge.
REQ-005 SHALL have port Reset, input, 1 bit, reset: asynchronous, active-high.
REQ-006 SHALL have port Tick, input, 1 bit, the global clock enable; state advances only when Tick=1.
REQ-007 SHALL have port Stall, input, 1 bit, the downstream stall; the PC holds while it is 1.
REQ-008 SHALL have ports BranchValid and BranchTaken, input, 1 bit each, the resolved conditional branch.
REQ-009 SHALL have ports BranchBase and BranchOffset, input, NrOfBits and 16 bits, the branch instruction address and its signed word offset.
REQ-010 SHALL have ports JumpValid and JumpTarget, input, 1 and NrOfBits bits, an absolute jump request.
REQ-011 SHALL have ports CallValid and RetValid, input, 1 bit each, a call (push return address and jump to JumpTarget) and a return.
REQ-012 SHALL have port PC, output, NrOfBits, the current fetch address.
REQ-013 SHALL have ports BranchInstructionAddress and BaLoad, output, NrOfBits and 1 bit, the redirect target and its one-cycle load strobe for the downstream branch-address register.
REQ-014 SHALL have port Flush, output, 1 bit, which squashes the instruction fetched behind a redirect.
REQ-015 SHALL have port RasEmpty, output, 1 bit, set when the return stack is empty.

Function
REQ-016 SHALL compute the branch target as BranchBase + (sign-extended BranchOffset << 2), modulo 2^NrOfBits, with no overflow flag.
REQ-017 SHALL apply request priority RetValid > CallValid > JumpValid > (BranchValid & BranchTaken); a not-taken branch is a no-op.
REQ-018 SHALL implement three states: RUN, PEND and REDIR.
REQ-019 In RUN with no request and Stall=0, SHALL advance PC by 4 on each Tick, wrapping at 2^NrOfBits.
REQ-020 In RUN with Stall=1 and no request, SHALL hold PC.
REQ-021 In RUN with a request and Stall=0, SHALL on the next Tick:
  - load PC with the target;
  - set BranchInstructionAddress to the target;
  - pulse BaLoad for one Tick;
  - go to REDIR.
REQ-022 In RUN with a request and Stall=1, SHALL capture the target into a pending register, hold PC and go to PEND.
REQ-023 In PEND, SHALL ignore new requests; on the first Tick with Stall=0 it SHALL perform the REQ-021 action using the pending target.
REQ-024 In REDIR, SHALL assert Flush for exactly one Tick, ignore all requests, advance PC by 4 unless Stall=1, and return to RUN.
REQ-025 When Tick=0, SHALL leave every register unchanged and keep BaLoad/Flush at their last values.
REQ-026 SHALL update BranchInstructionAddress only together with a BaLoad pulse.

Reset
REQ-027 Reset SHALL immediately force:
  - PC=ResetVector;
  - BranchInstructionAddress=0;
  - BaLoad=0, Flush=0;
  - state RUN;
  - pending target cleared;
  - return stack emptied (RasEmpty=1).
REQ-028 Reset asserted in PEND or REDIR SHALL discard the pending redirect with no BaLoad pulse after release.

Configuration
REQ-029 Macro PC_BRANCH_SEQUENCER_RETURN_STACK_EN SHALL compile in a RasDepth-entry return stack.
REQ-030 With the macro defined:
  - an accepted CallValid SHALL push PC+4;
  - an accepted RetValid SHALL pop and redirect to the popped value;
  - a push when full SHALL overwrite the oldest entry;
  - a pop when empty SHALL redirect to ResetVector.
REQ-031 Without the macro, CallValid SHALL behave as JumpValid, RetValid SHALL be ignored, and RasEmpty SHALL be tied to 1.

Structure
REQ-032 SHALL place the state enumeration (RUN/PEND/REDIR), the PC increment constant 4 and the offset width 16 in the shared CPU package.
REQ-033 SHALL implement the return stack as sub-module pc_return_stack, instantiated only under the macro.

Verification
REQ-034 Reset then 3 Ticks -> PC=0,4,8,12; BaLoad=0, Flush=0.
REQ-035 PC=0x100, branch taken with BranchBase=0x100 and BranchOffset=-2 -> PC=0xF8, BranchInstructionAddress=0xF8, BaLoad=1 one Tick, Flush=1 the next Tick, then PC=0xFC.
REQ-036 JumpValid to 0x40 with Stall=1 for 3 Ticks -> PC held, no BaLoad; on Stall release -> PC=0x40, BaLoad pulse.
REQ-037 JumpValid and branch taken in the same cycle -> JumpTarget wins; a second request during REDIR is ignored.
REQ-038 Macro on, RasDepth=4: 5 calls from PC=0x10,0x20,0x30,0x40,0x50, then 5 returns -> targets 0x54,0x44,0x34,0x24, then ResetVector; RasEmpty=1 at the end.
REQ-039 Reset asserted in PEND -> PC=ResetVector, and no BaLoad after release.
